// File: rtl/cell_pkg.sv
// Shared definitions for the cell RAM arbiter: default widths, requester ids
// and the arbiter state encoding.
package cell_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_LOAD  = 2'd0;
  localparam port_id_t PORT_SWEEP = 2'd1;
  localparam port_id_t PORT_DISP  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [2:0] port_onehot(input port_id_t p);
    return 3'b001 << p;
  endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Carries the owner id of each read beat through a READ_LAT-deep pipe so the
// matching rvalid pulse lines up with the RAM's read data.
module rd_return_pipe
  import cell_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clka,
  input  logic              reset_n,
  input  logic              i_push,
  input  port_id_t          i_push_id,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [2:0]        o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  logic [READ_LAT-1:0]      r_vld;
  logic [READ_LAT-1:0][1:0] r_id;

  // NOTE: the id stages are cleared with the valid bits even though only the
  // valid bits matter; a small pipe like this costs nothing to reset and keeps
  // X out of o_rvalid decoding after reset.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= i_push;
      r_id[0]  <= i_push_id;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign o_rvalid = r_vld[READ_LAT-1] ? port_onehot(r_id[READ_LAT-1]) : 3'b000;
  // The RAM's own output register provides the latency; no extra stage here.
  assign o_rdata  = i_ram_rdata;

endmodule

// File: rtl/cell_ram_arbiter.sv
// Single-port cell RAM arbiter: port 0 fixed priority, ports 1/2 round-robin,
// locked bursts of up to MAX_BURST beats with one bubble between owners.
module cell_ram_arbiter
  import cell_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                clka,
  input  logic                reset_n,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       r_state, w_state_nxt;
  port_id_t         r_owner, w_owner_nxt;
  port_id_t         r_rr_last, w_rr_last_nxt;
  port_id_t         w_winner;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [2:0]       r_gnt, w_gnt_nxt;

  logic              w_beat;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel_we    = we[0];
    w_sel_addr  = addr[0 +: ADDR_W];
    w_sel_wdata = wdata[0 +: DATA_W];
    case (r_owner)
      PORT_SWEEP: begin
        w_sel_we    = we[1];
        w_sel_addr  = addr[ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[DATA_W +: DATA_W];
      end
      PORT_DISP: begin
        w_sel_we    = we[2];
        w_sel_addr  = addr[2*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign w_beat = (r_state == GRANT) && req[r_owner];

  always_comb begin
    w_winner = PORT_SWEEP;
    if (req[PORT_LOAD]) begin
      w_winner = PORT_LOAD;
    end else if (req[PORT_SWEEP] && req[PORT_DISP]) begin
      w_winner = (r_rr_last == PORT_SWEEP) ? PORT_DISP : PORT_SWEEP;
    end else if (req[PORT_DISP]) begin
      w_winner = PORT_DISP;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_last_nxt  = r_rr_last;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gnt_nxt      = r_gnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt    = GRANT;
          w_owner_nxt    = w_winner;
          w_gnt_nxt      = port_onehot(w_winner);
          w_beat_cnt_nxt = '0;
          if (w_winner != PORT_LOAD) w_rr_last_nxt = w_winner;
        end
      end
      GRANT: begin
        if (!req[r_owner] || (w_beat && (r_beat_cnt == LAST_BEAT))) begin
          w_state_nxt    = IDLE;
          w_gnt_nxt      = 3'b000;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 3'b000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_owner    <= PORT_LOAD;
      r_rr_last  <= PORT_DISP;
      r_beat_cnt <= '0;
      r_gnt      <= 3'b000;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_last  <= w_rr_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state == GRANT);
  assign ram_en    = w_beat;
  assign ram_we    = w_beat && w_sel_we;
  assign ram_addr  = w_sel_addr;
  assign ram_wdata = w_sel_wdata;

  rd_return_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_return_pipe (
    .clka        (clka),
    .reset_n     (reset_n),
    .i_push      (w_beat && !w_sel_we),
    .i_push_id   (r_owner),
    .i_ram_rdata (ram_rdata),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata)
  );

endmodule

// File: doc/cell_ram_arbiter.md
Name: cell_ram_arbiter

Overview:
- Shares the single-port cell RAM among three requesters: host pattern load (port 0), generation sweep engine (port 1) and display scan-out (port 2).
- Port 0 has fixed highest priority. Ports 1 and 2 alternate round-robin.
- Each grant is a locked burst of at most MAX_BURST beats. Read data returns to the owning port a fixed READ_LAT cycles after each read beat.
- Sits between the game FSM's load/read/writeout strobes and the cell RAM.

Parameters:
- ADDR_W, 9, cell address width (512 cells, matches the 9-bit sweep counter).
- DATA_W, 8, RAM word width.
- MAX_BURST, 16, maximum beats per grant (must be ≥1, power of two not required).
- READ_LAT, 1, RAM read latency in cycles (1 or 2 supported).

Ports:
- clka  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  3  per-port request, level, held while the port has beats pending.
- we  in  3  per-port write enable for the current beat.
- addr  in  3*ADDR_W  per-port beat address; port i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  per-port write data, packed the same way.
- gnt  out  3  registered one-hot grant, or all-zero.
- rvalid  out  3  per-port read-data-valid pulse.
- rdata  out  DATA_W  read data, common to all ports; qualified by rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid READ_LAT cycles after a read ram_en.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, gnt=0, rvalid=0, beat_cnt=0.
  - rr_last=2, so port 1 wins the first 1-vs-2 tie.
  - Return pipeline is cleared.
  - Reset mid-burst discards in-flight reads: no rvalid appears after reset.
- States: IDLE and GRANT.
- IDLE:
  - gnt=0, ram_en=0.
  - At a clock edge with any req bit high:
    - If req[0]=1, winner is port 0.
    - Otherwise, if exactly one of req[1]/req[2] is high, winner is that port.
    - If both are high, winner is the port other than rr_last.
  - The edge sets gnt[winner]=1, beat_cnt=0 and moves to GRANT. If winner is 1 or 2, rr_last=winner.
  - If no req is high, stay in IDLE.
- GRANT, owner o:
  - A beat issues in any cycle with gnt[o]=1 and req[o]=1. ram_en, ram_we, ram_addr and ram_wdata are driven combinationally from port o's we/addr/wdata.
  - On each beat, beat_cnt increments.
  - Release happens at an edge where req[o]=0, or where a beat issues with beat_cnt==MAX_BURST-1.
  - On release: gnt=0 and state returns to IDLE, giving exactly one bubble cycle between owners.
  - A req[0] arriving mid-burst does not preempt the owner; port 0 waits for the burst to end. Worst-case wait is MAX_BURST+1 cycles.
  - With no preemption, port 1/2 waits are bounded by roughly (MAX_BURST+1) per intervening port-0 burst.
- Read return:
  - A read beat (ram_we=0) pushes its owner id into a READ_LAT-deep shift pipe.
  - rvalid[id]=1 for exactly one cycle, READ_LAT cycles after the beat. rdata=ram_rdata, registered-through.
  - Returns complete even if the grant has been released or handed to another port. Ordering is strictly issue order.
- Write beats produce no rvalid.
- Undefined inputs on non-owner ports are ignored.
- gnt never has more than one bit set. ram_en=0 whenever gnt=0.

Decomposition:
- Shared package (cell_pkg): ADDR_W/DATA_W defaults, port index constants (PORT_LOAD=0, PORT_SWEEP=1, PORT_DISP=2), arbiter state encoding (IDLE=1'b0, GRANT=1'b1).
- One natural sub-module: rd_return_pipe. It holds the READ_LAT-deep owner-id/valid shift register and drives rvalid/rdata.

Test Plan:
- Single port 1 read burst of 4, addr 0..3 → gnt[1] rises one edge after req; 4 beats with ram_addr 0,1,2,3; rvalid[1] 4 pulses, each READ_LAT cycles after its beat; release, then one idle cycle.
- req[1] and req[2] held continuously, MAX_BURST=16 → alternating grants 1,2,1,2. Each grant has exactly 16 beats with one bubble between; no port gets two consecutive grants.
- Port 2 mid-burst at beat 5, req[0] rises → port 2 completes to beat 16, then port 0 is granted ahead of a pending req[1]. Port 0 wait ≤ 17 cycles.
- Read beat on last cycle of port 1 grant, then handover to port 2 → rvalid[1] still fires READ_LAT cycles later; rvalid[2] stays 0 for that return.
- reset_n pulsed low during a port 1 read burst with reads in flight → gnt, rvalid and busy go 0 immediately. No stale rvalid after reset_n=1. First 1-vs-2 tie grants port 1.
- Interleaved write beats (we=1, data 0xA5 to addr 0x1FF) → ram_we=1 with matching address/data, and no rvalid is generated.
